// File: rtl/slide_wipe_sequencer.sv
// Frame-synchronous wipe-bar controller for the 2-to-1 slide-wipe mux.
// Position, direction and mode change only on a start-of-frame so the split never tears mid-frame.
module slide_wipe_sequencer #(
  parameter int C_H_ACTIVE     = 1920,
  parameter int C_SLIDE_PWIDTH = 5,
  parameter int C_STEP_FRAMES  = 1,
  parameter int C_STEP_PIXELS  = 4,
  parameter int C_DWELL_FRAMES = 60
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_vid_vsync,
  input  logic        i_cfg_valid,
  output logic        o_cfg_ready,
  input  logic [1:0]  i_cfg_mode,
  input  logic [11:0] i_cfg_pos,
  output logic [11:0] o_slide_pos,
  output logic        o_slide_dir,
  output logic        o_frame_tick,
  output logic        o_at_end
);

  localparam logic [12:0] MAXP13     = 13'(C_H_ACTIVE - C_SLIDE_PWIDTH);
  localparam logic [11:0] MAXP12     = 12'(C_H_ACTIVE - C_SLIDE_PWIDTH);
  localparam logic [12:0] STEP13     = 13'(C_STEP_PIXELS);
  localparam logic [11:0] STEP12     = 12'(C_STEP_PIXELS);
  localparam logic [15:0] STEP_LAST  = 16'(C_STEP_FRAMES - 1);
  localparam logic [15:0] DWELL_LAST = 16'(C_DWELL_FRAMES - 1);
  localparam bit          NO_DWELL   = (C_DWELL_FRAMES == 0);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_DWELL  = 2'd2,
    ST_MANUAL = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] pos, pos_nxt;
  logic [11:0] target, target_nxt;
  logic        dir, dir_nxt;
  logic [15:0] frame_cnt, frame_cnt_nxt;
  logic [15:0] dwell_cnt, dwell_cnt_nxt;
  logic        tick;

  logic        vs_d;
  logic        sof;
  logic        pending;
  logic        accept;
  logic        apply;
  logic [1:0]  shadow_mode;
  logic [11:0] shadow_pos;

  logic [12:0] up_sum;
  logic [11:0] step_up, step_dn, step_pos;
  logic        step_hit;
  logic [11:0] man_pos;
  logic        man_dir;

  assign sof         = vs_d & ~i_vid_vsync;
  assign accept      = i_cfg_valid & ~pending;
  assign apply       = sof & pending;
  assign o_cfg_ready = ~pending;

  // Accept and apply are mutually exclusive, so a request taken on a sof waits for the next one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vs_d        <= 1'b0;
      pending     <= 1'b0;
      shadow_mode <= 2'd0;
      shadow_pos  <= '0;
    end else begin
      vs_d <= i_vid_vsync;
      if (apply) begin
        pending <= 1'b0;
      end else if (accept) begin
        pending     <= 1'b1;
        shadow_mode <= i_cfg_mode;
        shadow_pos  <= (i_cfg_pos > MAXP12) ? MAXP12 : i_cfg_pos;
      end
    end
  end

  always_comb begin
    up_sum   = {1'b0, pos} + STEP13;
    step_up  = (up_sum >= MAXP13) ? MAXP12 : up_sum[11:0];
    step_dn  = ({1'b0, pos} > STEP13) ? (pos - STEP12) : 12'd0;
    step_pos = dir ? step_dn : step_up;
    step_hit = dir ? (step_pos == 12'd0) : (step_pos == MAXP12);
    man_pos  = pos;
    man_dir  = 1'b0;
    if (target > pos) begin
      man_pos = ((target - pos) > STEP12) ? (pos + STEP12) : target;
    end else if (target < pos) begin
      man_pos = ((pos - target) > STEP12) ? (pos - STEP12) : target;
      man_dir = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    pos_nxt       = pos;
    dir_nxt       = dir;
    target_nxt    = target;
    frame_cnt_nxt = frame_cnt;
    dwell_cnt_nxt = dwell_cnt;
    if (apply) begin
      frame_cnt_nxt = '0;
      dwell_cnt_nxt = '0;
      case (shadow_mode)
        2'd1: begin
          state_nxt = ST_MOVE;
          // Entering auto while already pinned against the bound it is heading for: turn around.
          if (!dir && pos == MAXP12) begin
            dir_nxt = 1'b1;
          end else if (dir && pos == 12'd0) begin
            dir_nxt = 1'b0;
          end
        end
        2'd2: begin
          state_nxt  = ST_MANUAL;
          target_nxt = shadow_pos;
        end
        default: state_nxt = ST_HOLD;
      endcase
    end else if (sof) begin
      case (state)
        ST_MOVE: begin
          if (frame_cnt == STEP_LAST) begin
            frame_cnt_nxt = '0;
            pos_nxt       = step_pos;
            if (step_hit) begin
              if (NO_DWELL) begin
                dir_nxt = ~dir;
              end else begin
                state_nxt     = ST_DWELL;
                dwell_cnt_nxt = '0;
              end
            end
          end else begin
            frame_cnt_nxt = frame_cnt + 16'd1;
          end
        end
        ST_DWELL: begin
          if (dwell_cnt == DWELL_LAST) begin
            dir_nxt       = ~dir;
            state_nxt     = ST_MOVE;
            frame_cnt_nxt = '0;
            dwell_cnt_nxt = '0;
          end else begin
            dwell_cnt_nxt = dwell_cnt + 16'd1;
          end
        end
        ST_MANUAL: begin
          pos_nxt = man_pos;
          dir_nxt = man_dir;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_HOLD;
      pos       <= '0;
      dir       <= 1'b0;
      target    <= '0;
      frame_cnt <= '0;
      dwell_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      dir       <= dir_nxt;
      target    <= target_nxt;
      frame_cnt <= frame_cnt_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      tick      <= sof;
    end
  end

  assign o_slide_pos  = pos;
  assign o_slide_dir  = dir;
  assign o_frame_tick = tick;
  assign o_at_end     = (((state == ST_MOVE) || (state == ST_DWELL)) &&
                         ((pos == 12'd0) || (pos == MAXP12))) ||
                        ((state == ST_MANUAL) && (pos == target));

endmodule
